acq_track_ctrl: RTL and testbench

- Acquisition/tracking sequencer for the punctual correlator + Costas/NCO channel.
- Generates 1 ms integrate-and-dump epochs and sweeps carrier-frequency bins and code phases until epoch power crosses a threshold.
- Confirms lock over several epochs, then closes the Costas loop; falls back to search on sustained loss of power.
- Drives NCO frequency offset, PRN code-slip and loop-enable; consumes epoch power from the correlator accumulators.

---
 rtl/acq_track_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_acq_track_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/acq_track_ctrl.sv
// rtl/acq_track_ctrl.sv - acquisition/tracking sequencer for the punctual correlator + Costas/NCO channel
// Optional macro ACQ_TRACK_STATS_EN adds the acq_epochs acquisition-time counter.
module acq_track_ctrl #(
  parameter int SAMPLES_PER_EPOCH = 16368,
  parameter int NUM_BINS          = 21,
  parameter int CODE_PHASES       = 1023,
  parameter int FREQ_STEP         = 64,
  parameter int POW_W             = 32,
  parameter int VERIFY_EPOCHS     = 4,
  parameter int LOSS_EPOCHS       = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic                pwr_valid,
  input  logic [POW_W-1:0]    pwr,
  input  logic [POW_W-1:0]    threshold,
  output logic                dump,
  output logic                code_slip,
  output logic signed [16:0]  freq_offset,
  output logic                loop_en,
  output logic                locked,
  output logic                sweep_done,
  output logic [1:0]          state,
  output logic [31:0]         acq_epochs
);
  localparam int SAMP_W = $clog2(SAMPLES_PER_EPOCH + 1);
  localparam int BIN_W  = $clog2(NUM_BINS + 1);
  localparam int CODE_W = $clog2(CODE_PHASES + 1);
  localparam int VER_W  = $clog2(VERIFY_EPOCHS + 1);
  localparam int LOSS_W = $clog2(LOSS_EPOCHS + 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLES_PER_EPOCH - 1);
  localparam logic [BIN_W-1:0]  BIN_LAST  = BIN_W'(NUM_BINS - 1);
  localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(CODE_PHASES - 1);
  localparam logic [VER_W-1:0]  VER_TGT   = VER_W'(VERIFY_EPOCHS);
  localparam logic [LOSS_W-1:0] LOSS_TGT  = LOSS_W'(LOSS_EPOCHS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_VERIFY = 2'd2, S_TRACK = 2'd3} state_t;

  state_t              r_state;
  logic [SAMP_W-1:0]   r_samp_cnt;
  logic [BIN_W-1:0]    r_bin_idx;
  logic [CODE_W-1:0]   r_code_idx;
  logic [VER_W-1:0]    r_verify_cnt;
  logic [LOSS_W-1:0]   r_miss_cnt;
  logic                r_blank;
  logic                r_dump, r_code_slip, r_sweep_done, r_loop_en, r_locked;
  logic signed [16:0]  r_freq_offset;

  logic                w_hit, w_acq_phase, w_eval, w_to_track, w_loss, w_code_wrap, w_bin_wrap;
  logic [VER_W-1:0]    w_vcnt_next;
  logic [LOSS_W-1:0]   w_miss_next;
  logic [BIN_W-1:0]    w_bin_next;
  logic [CODE_W-1:0]   w_code_next;

  function automatic logic signed [16:0] bin_freq(input logic [BIN_W-1:0] b);
    return 17'((int'(b) - (NUM_BINS - 1) / 2) * FREQ_STEP);
  endfunction

  assign w_hit       = (pwr >= threshold);
  assign w_acq_phase = (r_state == S_SEARCH) || (r_state == S_VERIFY);
  // A blanked pulse is accepted but never evaluated as hit or miss.
  assign w_eval      = enable && pwr_valid && w_acq_phase && !r_blank;
  assign w_vcnt_next = (r_state == S_SEARCH) ? VER_W'(1) : r_verify_cnt + VER_W'(1);
  assign w_to_track  = w_eval && w_hit && (w_vcnt_next >= VER_TGT);
  assign w_miss_next = r_miss_cnt + LOSS_W'(1);
  assign w_loss      = enable && pwr_valid && (r_state == S_TRACK) && !w_hit && (w_miss_next >= LOSS_TGT);
  assign w_code_wrap = (r_code_idx == CODE_LAST);
  assign w_bin_wrap  = (r_bin_idx == BIN_LAST);
  assign w_code_next = w_code_wrap ? '0 : r_code_idx + CODE_W'(1);
  assign w_bin_next  = !w_code_wrap ? r_bin_idx : (w_bin_wrap ? '0 : r_bin_idx + BIN_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      r_samp_cnt    <= '0;
      r_bin_idx     <= '0;
      r_code_idx    <= '0;
      r_verify_cnt  <= '0;
      r_miss_cnt    <= '0;
      r_blank       <= 1'b0;
      r_dump        <= 1'b0;
      r_code_slip   <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_loop_en     <= 1'b0;
      r_locked      <= 1'b0;
      r_freq_offset <= '0;
    end else begin
      r_dump       <= 1'b0;
      r_code_slip  <= 1'b0;
      r_sweep_done <= 1'b0;

      if (!enable || r_state == S_IDLE) begin
        r_samp_cnt <= '0;
      end else if (sample_valid) begin
        if (r_samp_cnt == SAMP_LAST) begin
          r_samp_cnt <= '0;
          r_dump     <= 1'b1;
        end else begin
          r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
        end
      end

      if (!enable) begin
        r_state       <= S_IDLE;
        r_bin_idx     <= '0;
        r_code_idx    <= '0;
        r_verify_cnt  <= '0;
        r_miss_cnt    <= '0;
        r_blank       <= 1'b0;
        r_loop_en     <= 1'b0;
        r_locked      <= 1'b0;
        r_freq_offset <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state       <= S_SEARCH;
            r_bin_idx     <= '0;
            r_code_idx    <= '0;
            r_blank       <= 1'b1;
            r_freq_offset <= bin_freq('0);
          end
          S_SEARCH, S_VERIFY: begin
            if (pwr_valid && r_blank) begin
              r_blank <= 1'b0;
            end else if (w_eval && w_hit) begin
              r_verify_cnt <= w_to_track ? '0 : w_vcnt_next;
              r_state      <= w_to_track ? S_TRACK : S_VERIFY;
              r_loop_en    <= w_to_track;
              r_locked     <= w_to_track;
            end else if (w_eval) begin
              // Miss: step to the next hypothesis and blank the contaminated epoch.
              r_state       <= S_SEARCH;
              r_verify_cnt  <= '0;
              r_code_slip   <= 1'b1;
              r_blank       <= 1'b1;
              r_code_idx    <= w_code_next;
              r_bin_idx     <= w_bin_next;
              r_sweep_done  <= w_code_wrap && w_bin_wrap;
              r_freq_offset <= bin_freq(w_bin_next);
            end
          end
          S_TRACK: begin
            if (pwr_valid) begin
              if (w_hit) begin
                r_miss_cnt <= '0;
              end else if (w_loss) begin
                r_state    <= S_SEARCH;
                r_miss_cnt <= '0;
                r_blank    <= 1'b1;
                r_loop_en  <= 1'b0;
                r_locked   <= 1'b0;
              end else begin
                r_miss_cnt <= w_miss_next;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dump        = r_dump;
  assign code_slip   = r_code_slip;
  assign sweep_done  = r_sweep_done;
  assign freq_offset = r_freq_offset;
  assign loop_en     = r_loop_en;
  assign locked      = r_locked;
  assign state       = r_state;

`ifdef ACQ_TRACK_STATS_EN
  logic [31:0] r_acq_epochs;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_acq_epochs <= '0;
    end else if ((enable && r_state == S_IDLE) || w_loss) begin
      r_acq_epochs <= '0;
    end else if (enable && pwr_valid && w_acq_phase && !w_to_track && r_acq_epochs != '1) begin
      r_acq_epochs <= r_acq_epochs + 32'd1;
    end
  end

  assign acq_epochs = r_acq_epochs;
`else
  assign acq_epochs = '0;
`endif
endmodule

// File: tb/tb_acq_track_ctrl.sv
// tb/tb_acq_track_ctrl.sv - directed table-driven bench for acq_track_ctrl
// Small-parameter configuration: 8 samples/epoch, 3 bins, 4 code phases, step 100.
module tb_acq_track_ctrl;
  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               enable = 1'b0;
  logic               sample_valid = 1'b0;
  logic               pwr_valid = 1'b0;
  logic [31:0]        pwr = '0;
  logic [31:0]        threshold = 32'd1000;
  logic               dump, code_slip, loop_en, locked, sweep_done;
  logic signed [16:0] freq_offset;
  logic [1:0]         state;
  logic [31:0]        acq_epochs;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ACQ_TRACK_STATS_EN
  localparam int EXP_ACQ = 14;
`else
  localparam int EXP_ACQ = 0;
`endif

  always #5 CLK = ~CLK;

  acq_track_ctrl #(
    .SAMPLES_PER_EPOCH(8), .NUM_BINS(3), .CODE_PHASES(4), .FREQ_STEP(100),
    .POW_W(32), .VERIFY_EPOCHS(2), .LOSS_EPOCHS(3)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .sample_valid(sample_valid),
    .pwr_valid(pwr_valid), .pwr(pwr), .threshold(threshold),
    .dump(dump), .code_slip(code_slip), .freq_offset(freq_offset),
    .loop_en(loop_en), .locked(locked), .sweep_done(sweep_done),
    .state(state), .acq_epochs(acq_epochs)
  );

  typedef struct {
    logic        en;
    logic        pv;
    logic [31:0] p;
    int          st;
    logic        slip;
    logic        swp;
    int          fo;
    logic        lp;
    logic        lk;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic pv, input int p, input int st,
                              input logic slip, input logic swp, input int fo,
                              input logic lp, input logic lk);
    vec_t v;
    v.en = en; v.pv = pv; v.p = p; v.st = st; v.slip = slip;
    v.swp = swp; v.fo = fo; v.lp = lp; v.lk = lk;
    return v;
  endfunction

  // Fresh SEARCH start: all-miss pulses alternate blank/slip; bin advances every 4 slips.
  task automatic add_misses(input int npulses);
    for (int k = 1; k <= npulses; k++) begin
      int nslip;
      int bin;
      nslip = k / 2;
      bin   = (nslip / 4) % 3;
      vq.push_back(mk(1'b1, 1'b1, 10, 1, (k % 2 == 0), (k == 24), (bin - 1) * 100, 1'b0, 1'b0));
    end
  endtask

  task automatic add_reenter();
    vq.push_back(mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 0, 1, 1'b0, 1'b0, -100, 1'b0, 1'b0));
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      enable    = vq[i].en;
      pwr_valid = vq[i].pv;
      pwr       = vq[i].p;
      tick();
      chk($sformatf("v%0d state", i), state, vq[i].st);
      chk($sformatf("v%0d code_slip", i), code_slip, vq[i].slip);
      chk($sformatf("v%0d sweep_done", i), sweep_done, vq[i].swp);
      chk($sformatf("v%0d freq_offset", i), freq_offset, vq[i].fo);
      chk($sformatf("v%0d loop_en", i), loop_en, vq[i].lp);
      chk($sformatf("v%0d locked", i), locked, vq[i].lk);
      pwr_valid = 1'b0;
      tick();
      chk($sformatf("v%0d gap state", i), state, vq[i].st);
      chk($sformatf("v%0d gap code_slip", i), code_slip, 1'b0);
      chk($sformatf("v%0d gap sweep_done", i), sweep_done, 1'b0);
    end
  endtask

  int m_sweep, m_acq, m_loss, m_end;

  initial begin
    add_reenter();
    add_misses(24);
    m_sweep = vq.size();
    add_reenter();
    add_misses(12);
    vq.push_back(mk(1'b1, 1'b1, 5000, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 5000, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 5000, 3, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    m_acq = vq.size();
    vq.push_back(mk(1'b1, 1'b1, 10,   3, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 1'b1, 10,   3, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 1'b1, 5000, 3, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 1'b1, 10,   3, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 1'b1, 10,   3, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 1'b1, 10,   1, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    m_loss = vq.size();
    vq.push_back(mk(1'b1, 1'b1, 5000, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 5000, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 5000, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    m_end = vq.size();

    // Reset held with enable high
    RST = 1'b0; enable = 1'b1;
    tick(); tick();
    chk("rst state", state, 0);
    chk("rst dump", dump, 0);
    chk("rst code_slip", code_slip, 0);
    chk("rst freq_offset", freq_offset, 0);
    chk("rst loop_en", loop_en, 0);
    chk("rst locked", locked, 0);
    chk("rst sweep_done", sweep_done, 0);
    chk("rst acq_epochs", acq_epochs, 0);
    RST = 1'b1;
    tick();
    chk("release state", state, 1);
    chk("release freq_offset", freq_offset, -100);

    // Epoch timing: continuous, then 50% gapped samples
    sample_valid = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      chk($sformatf("dump cont c%0d", c), dump, (c % 8 == 0));
    end
    for (int c = 1; c <= 64; c++) begin
      sample_valid = (c % 2 == 1);
      tick();
      chk($sformatf("dump gap c%0d", c), dump, (c % 16 == 15));
    end
    sample_valid = 1'b0;

    run_vectors(0, m_sweep);
    run_vectors(m_sweep, m_acq);
    chk("acq_epochs at lock", acq_epochs, EXP_ACQ);
    run_vectors(m_acq, m_loss);
    chk("acq_epochs after loss", acq_epochs, 0);
    run_vectors(m_loss, m_end);
    chk("abort dump", dump, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
